// File: rtl/alu_result_unit_if.sv
// Operand, handshake and status signals between the operand registers and alu_result_unit.
// ALU_MULHI_EN adds resHiOut_i, which selects the multiply high half onto the data bus.
interface alu_result_unit_if #(
  parameter int Width = 16
);
  logic [Width-1:0] opA_i;
  logic [Width-1:0] opB_i;
  logic [2:0]       op_i;
  logic             start_i;
  logic             resOut_i;
`ifdef ALU_MULHI_EN
  logic             resHiOut_i;
`endif
  logic             busy_o;
  logic             done_o;
  logic [3:0]       flags_o;

`ifdef ALU_MULHI_EN
  modport slave (
    input  opA_i, opB_i, op_i, start_i, resOut_i, resHiOut_i,
    output busy_o, done_o, flags_o
  );
  modport master (
    output opA_i, opB_i, op_i, start_i, resOut_i, resHiOut_i,
    input  busy_o, done_o, flags_o
  );
`else
  modport slave (
    input  opA_i, opB_i, op_i, start_i, resOut_i,
    output busy_o, done_o, flags_o
  );
  modport master (
    output opA_i, opB_i, op_i, start_i, resOut_i,
    input  busy_o, done_o, flags_o
  );
`endif
endinterface

// File: rtl/alu_result_unit.sv
// Sequential ALU stage: single-cycle ops plus an iterative shift-add multiply, result driven on a tristate bus.
// Optional macro ALU_MULHI_EN keeps the multiply high half in a hi register readable via resHiOut_i.
module alu_result_unit #(
  parameter int Width = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  inout  wire  [Width-1:0] bus_io,
  alu_result_unit_if.slave ifc
);
  localparam int CntW = (Width > 1) ? $clog2(Width) : 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StMul  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpAnd = 3'b010;
  localparam logic [2:0] OpOr  = 3'b011;
  localparam logic [2:0] OpXor = 3'b100;
  localparam logic [2:0] OpShl = 3'b101;
  localparam logic [2:0] OpShr = 3'b110;
  localparam logic [2:0] OpMul = 3'b111;

  logic [1:0]         state_q,  state_d;
  logic [Width-1:0]   result_q, result_d;
  logic [3:0]         flags_q,  flags_d;
  logic [2*Width-1:0] mcand_q,  mcand_d;
  logic [2*Width-1:0] acc_q,    acc_d;
  logic [Width-1:0]   mplier_q, mplier_d;
  logic [CntW-1:0]    count_q,  count_d;
`ifdef ALU_MULHI_EN
  logic [Width-1:0]   hi_q,     hi_d;
`endif

  logic [Width-1:0]   aluRes;
  logic               aluC;
  logic               aluV;
  logic [Width:0]     addExt;
  logic [Width:0]     subExt;
  logic [Width:0]     shlExt;
  logic [Width:0]     shrExt;
  logic [3:0]         shAmt;
  logic [2*Width-1:0] accStep;
  logic               mulHiNz;

  function automatic logic [3:0] mkFlags(input logic [Width-1:0] r, input logic c, input logic v);
    return {(r == '0), r[Width-1], c, v};
  endfunction

  // The extra bit on each shift catches the last bit shifted out; a zero shift leaves it 0.
  always_comb begin
    shAmt  = ifc.opB_i[3:0];
    addExt = {1'b0, ifc.opA_i} + {1'b0, ifc.opB_i};
    subExt = {1'b0, ifc.opA_i} - {1'b0, ifc.opB_i};
    shlExt = {1'b0, ifc.opA_i} << shAmt;
    shrExt = {ifc.opA_i, 1'b0} >> shAmt;
    aluRes = '0;
    aluC   = 1'b0;
    aluV   = 1'b0;
    case (ifc.op_i)
      OpAdd: begin
        aluRes = addExt[Width-1:0];
        aluC   = addExt[Width];
        aluV   = (ifc.opA_i[Width-1] == ifc.opB_i[Width-1]) &&
                 (aluRes[Width-1] != ifc.opA_i[Width-1]);
      end
      OpSub: begin
        aluRes = subExt[Width-1:0];
        aluC   = subExt[Width];
        aluV   = (ifc.opA_i[Width-1] != ifc.opB_i[Width-1]) &&
                 (aluRes[Width-1] != ifc.opA_i[Width-1]);
      end
      OpAnd:   aluRes = ifc.opA_i & ifc.opB_i;
      OpOr:    aluRes = ifc.opA_i | ifc.opB_i;
      OpXor:   aluRes = ifc.opA_i ^ ifc.opB_i;
      OpShl:   {aluC, aluRes} = shlExt;
      OpShr:   {aluRes, aluC} = shrExt;
      default: aluRes = '0;
    endcase
  end

  always_comb begin
    accStep = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    mulHiNz = (accStep[2*Width-1:Width] != '0);
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    flags_d  = flags_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    count_d  = count_q;
`ifdef ALU_MULHI_EN
    hi_d     = hi_q;
`endif
    case (state_q)
      StIdle, StDone: begin
        if (ifc.start_i) begin
          if (ifc.op_i == OpMul) begin
            mcand_d  = {{Width{1'b0}}, ifc.opA_i};
            mplier_d = ifc.opB_i;
            acc_d    = '0;
            count_d  = '0;
            state_d  = StMul;
          end else begin
            result_d = aluRes;
            flags_d  = mkFlags(aluRes, aluC, aluV);
            state_d  = StDone;
          end
        end else begin
          state_d = StIdle;
        end
      end
      StMul: begin
        acc_d    = accStep;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + CntW'(1);
        if (count_q == CntW'(Width - 1)) begin
          result_d = accStep[Width-1:0];
          flags_d  = mkFlags(accStep[Width-1:0], mulHiNz, mulHiNz);
`ifdef ALU_MULHI_EN
          hi_d     = accStep[2*Width-1:Width];
`endif
          state_d  = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      result_q <= '0;
      flags_q  <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      count_q  <= '0;
`ifdef ALU_MULHI_EN
      hi_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      count_q  <= count_d;
`ifdef ALU_MULHI_EN
      hi_q     <= hi_d;
`endif
    end
  end

  assign ifc.busy_o  = (state_q == StMul);
  assign ifc.done_o  = (state_q == StDone);
  assign ifc.flags_o = flags_q;

  // The tristate stays a plain module port so it resolves on the shared top-level net.
`ifdef ALU_MULHI_EN
  assign bus_io = ifc.resOut_i   ? result_q :
                  ifc.resHiOut_i ? hi_q     : {Width{1'bz}};
`else
  assign bus_io = ifc.resOut_i ? result_q : {Width{1'bz}};
`endif
endmodule

// File: tb/tb_alu_result_unit.sv
// Self-checking bench for alu_result_unit: directed vectors, a behavioural reference model
// checked every cycle, and hand-computed literal expectations.
module tb_alu_result_unit;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  wire  [W-1:0] bus;

  alu_result_unit_if #(.Width(W)) ifc();

  alu_result_unit #(.Width(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus),
    .ifc    (ifc)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic [W-1:0] expResult, expHi, pendRes, pendHi;
  logic [3:0]   expFlags, pendFlags;
  logic         expBusy, expDone;
  int           mulLeft;

  function automatic void refOp(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] res, output logic [3:0] fl, output logic [W-1:0] hi);
    logic [31:0]  p;
    logic [W-1:0] t;
    logic         c, v;
    int           ss, sh;
    c  = 1'b0;
    v  = 1'b0;
    hi = '0;
    sh = int'(b[3:0]);
    case (op)
      3'd0: begin
        p   = 32'(a) + 32'(b);
        res = p[W-1:0];
        c   = p[W];
        ss  = int'($signed(a)) + int'($signed(b));
        v   = (ss > 32767) || (ss < -32768);
      end
      3'd1: begin
        res = a - b;
        c   = (a < b);
        ss  = int'($signed(a)) - int'($signed(b));
        v   = (ss > 32767) || (ss < -32768);
      end
      3'd2: res = a & b;
      3'd3: res = a | b;
      3'd4: res = a ^ b;
      3'd5: begin
        p   = 32'(a) << sh;
        res = p[W-1:0];
        c   = (sh != 0) && p[W];
      end
      3'd6: begin
        res = a >> sh;
        if (sh != 0) begin
          t = a >> (sh - 1);
          c = t[0];
        end
      end
      default: begin
        p   = 32'(a) * 32'(b);
        res = p[W-1:0];
        hi  = p[31:16];
        c   = (hi != '0);
        v   = c;
      end
    endcase
    fl = {(res == '0), res[W-1], c, v};
  endfunction

  // Reference model: single ops land at the Start edge, multiply lands W edges later.
  always @(posedge clk or negedge rst_n) begin : model
    logic [W-1:0] r, h;
    logic [3:0]   f;
    if (!rst_n) begin
      expResult <= '0;
      expHi     <= '0;
      expFlags  <= '0;
      expBusy   <= 1'b0;
      expDone   <= 1'b0;
      mulLeft   <= 0;
      pendRes   <= '0;
      pendHi    <= '0;
      pendFlags <= '0;
    end else if (mulLeft > 0) begin
      mulLeft <= mulLeft - 1;
      if (mulLeft == 1) begin
        expResult <= pendRes;
        expFlags  <= pendFlags;
        expHi     <= pendHi;
        expBusy   <= 1'b0;
        expDone   <= 1'b1;
      end
    end else if (ifc.start_i) begin
      refOp(ifc.op_i, ifc.opA_i, ifc.opB_i, r, f, h);
      if (ifc.op_i == 3'b111) begin
        pendRes   <= r;
        pendFlags <= f;
        pendHi    <= h;
        mulLeft   <= W;
        expBusy   <= 1'b1;
        expDone   <= 1'b0;
      end else begin
        expResult <= r;
        expFlags  <= f;
        expDone   <= 1'b1;
      end
    end else begin
      expDone <= 1'b0;
    end
  end

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checkOutput("model busy", W'(ifc.busy_o), W'(expBusy));
      checkOutput("model done", W'(ifc.done_o), W'(expDone));
      checkOutput("model flags", W'(ifc.flags_o), W'(expFlags));
      if (ifc.resOut_i) checkOutput("model bus", bus, expResult);
`ifdef ALU_MULHI_EN
      else if (ifc.resHiOut_i) checkOutput("model bus hi", bus, expHi);
`endif
    end
  end

  task automatic applyStimulus(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    ifc.op_i    = op;
    ifc.opA_i   = a;
    ifc.opB_i   = b;
    ifc.start_i = 1'b1;
    @(negedge clk);
    ifc.start_i = 1'b0;
  endtask

  task automatic waitDone(input string name);
    for (int i = 0; i < 40 && !ifc.done_o; i++) @(negedge clk);
    if (!ifc.done_o) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL %s timeout: done got 0, want 1", name);
    end
  endtask

  task automatic runOp(input string name, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] expRes, input logic [3:0] expFl);
    applyStimulus(op, a, b);
    waitDone(name);
    checkOutput({name, " result"}, bus, expRes);
    checkOutput({name, " flags"}, W'(ifc.flags_o), W'(expFl));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  busyCnt;
    int  doneCnt;
    rst_n         = 1'b0;
    ifc.opA_i     = '0;
    ifc.opB_i     = '0;
    ifc.op_i      = '0;
    ifc.start_i   = 1'b0;
    ifc.resOut_i  = 1'b1;
`ifdef ALU_MULHI_EN
    ifc.resHiOut_i = 1'b0;
`endif
    repeat (3) @(negedge clk);
    checkOutput("reset bus", bus, 16'h0000);
    checkOutput("reset flags", W'(ifc.flags_o), 16'h0);
    checkOutput("reset busy", W'(ifc.busy_o), 16'h0);
    checkOutput("reset done", W'(ifc.done_o), 16'h0);
    rst_n = 1'b1;

    runOp("add ovf", 3'b000, 16'h7FFF, 16'h0001, 16'h8000, 4'b0101);
    checkOutput("model pin add", expResult, 16'h8000);
    @(negedge clk);
    ifc.resOut_i = 1'b0;
    @(negedge clk);
    ifc.resOut_i = 1'b1;
    runOp("sub borrow", 3'b001, 16'h0003, 16'h0005, 16'hFFFE, 4'b0110);
    runOp("sub sovf", 3'b001, 16'h8000, 16'h0001, 16'h7FFF, 4'b0001);
    runOp("and zero", 3'b010, 16'h00F0, 16'h0F0F, 16'h0000, 4'b1000);
    runOp("or", 3'b011, 16'h1200, 16'h0034, 16'h1234, 4'b0000);
    runOp("xor zero", 3'b100, 16'hAAAA, 16'hAAAA, 16'h0000, 4'b1000);
    runOp("shl 1", 3'b101, 16'h8001, 16'h0001, 16'h0002, 4'b0010);
    runOp("shr 2", 3'b110, 16'h0003, 16'h0002, 16'h0000, 4'b1010);
    runOp("shl 0", 3'b101, 16'h1234, 16'h0000, 16'h1234, 4'b0000);
    runOp("shr 15", 3'b110, 16'h8000, 16'h000F, 16'h0001, 4'b0000);
    checkOutput("model pin shr", W'(expFlags), 16'h0);

    applyStimulus(3'b111, 16'h0123, 16'h0010);
    busyCnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (!ifc.busy_o) break;
      busyCnt++;
      @(negedge clk);
    end
    checkOutput("mul busy cycles", W'(busyCnt), 16'd16);
    checkOutput("mul done", W'(ifc.done_o), 16'h1);
    checkOutput("mul result", bus, 16'h1230);
    checkOutput("mul flags", W'(ifc.flags_o), 16'h0);

    runOp("mul big", 3'b111, 16'h1000, 16'h0100, 16'h0000, 4'b1011);
    checkOutput("model pin mul", W'(expFlags), 16'hB);
`ifdef ALU_MULHI_EN
    @(negedge clk);
    ifc.resOut_i   = 1'b0;
    ifc.resHiOut_i = 1'b1;
    @(negedge clk);
    checkOutput("mul hi bus", bus, 16'h0010);
    ifc.resOut_i = 1'b1;
    @(negedge clk);
    checkOutput("resout wins", bus, 16'h0000);
    ifc.resHiOut_i = 1'b0;
`endif

    applyStimulus(3'b111, 16'h00FF, 16'h0101);
    repeat (3) @(negedge clk);
    ifc.op_i    = 3'b000;
    ifc.opA_i   = 16'h0001;
    ifc.opB_i   = 16'h0001;
    ifc.start_i = 1'b1;
    @(negedge clk);
    ifc.start_i = 1'b0;
    checkOutput("start in mul busy", W'(ifc.busy_o), 16'h1);
    waitDone("mul ignore start");
    checkOutput("mul ignore result", bus, 16'hFFFF);
    checkOutput("mul ignore flags", W'(ifc.flags_o), 16'h4);

    @(negedge clk);
    ifc.op_i    = 3'b000;
    ifc.opA_i   = 16'h0002;
    ifc.opB_i   = 16'h0003;
    ifc.start_i = 1'b1;
    @(negedge clk);
    checkOutput("b2b first done", W'(ifc.done_o), 16'h1);
    checkOutput("b2b first result", bus, 16'h0005);
    ifc.op_i  = 3'b100;
    ifc.opA_i = 16'hF0F0;
    ifc.opB_i = 16'h0F0F;
    @(negedge clk);
    ifc.start_i = 1'b0;
    checkOutput("b2b second done", W'(ifc.done_o), 16'h1);
    checkOutput("b2b second result", bus, 16'hFFFF);
    checkOutput("b2b second flags", W'(ifc.flags_o), 16'h4);
    @(negedge clk);
    checkOutput("b2b idle done", W'(ifc.done_o), 16'h0);

    applyStimulus(3'b111, 16'h0002, 16'h0003);
    checkOutput("stale bus in mul", bus, 16'hFFFF);
    waitDone("mul small");
    checkOutput("mul small result", bus, 16'h0006);

    applyStimulus(3'b111, 16'h0123, 16'h0010);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort busy", W'(ifc.busy_o), 16'h0);
    checkOutput("abort done", W'(ifc.done_o), 16'h0);
    checkOutput("abort bus", bus, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    doneCnt = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (ifc.done_o) doneCnt++;
    end
    checkOutput("abort no done", W'(doneCnt), 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/alu_result_unit.md
Name: alu_result_unit

Overview:
Sequential ALU stage on the far side of the operand registers. It consumes the two operand words they present and computes a result under a Start/Busy/Done handshake. Single-cycle ops complete in one clock; multiply is an iterative shift-add. The result and flags are held in registers, and the result is driven back onto the shared tristate data bus on request.

Parameters:
Width, 16, datapath/result width; Bus width equals Width.

Ports:
Clk  input  1  system clock, rising edge
Rst_n  input  1  asynchronous active-low reset
Bus  inout  Width  shared data bus; driven only while ResOut=1, else high-Z
OpA  input  Width  operand A, from the A operand register
OpB  input  Width  operand B, from the B operand register
Op  input  3  opcode, sampled with Start
Start  input  1  begin operation; honoured only in IDLE or DONE
ResOut  input  1  drive the result register onto Bus
Busy  output  1  multiply in progress
Done  output  1  one-cycle pulse: result/flags just updated
Flags  output  4  {Z,N,C,V} registered with the result

Behaviour:
- Reset (async, Rst_n=0):
  - state=IDLE; result=0; Flags=0; Busy=0; Done=0; iteration counter=0.
  - Bus is high-Z unless ResOut=1, in which case it drives 0.
  - Reset mid-multiply aborts; no Done is produced.
- States: IDLE, MUL, DONE.
  - IDLE/DONE with Start=1, Op!=111: result and Flags load at that edge from live OpA/OpB; next state DONE.
  - IDLE/DONE with Start=1, Op=111: capture OpA, OpB; clear accumulator and counter; next state MUL.
  - IDLE/DONE with Start=0: next state IDLE.
  - MUL: one shift-add step per edge; after Width steps, result and Flags load; next state DONE.
- Done=1 exactly in DONE. Busy=1 exactly in MUL.
- Latency, counted as rising edges from the Start sample edge to the result-load edge:
  - single-cycle ops: 0; Done high the following cycle.
  - MUL: Width (16 by default); Done high after Width+1 edges counted from the Start sample edge.
- Start while Busy is ignored and has no effect on the operation in progress.
- Start while in DONE is accepted: back-to-back ops with no IDLE cycle.
- Op encoding (all results truncated to Width):
  - 000 ADD A+B. C=carry out. V=signed overflow.
  - 001 SUB A-B. C=1 iff A<B unsigned (borrow). V=signed overflow.
  - 010 AND, 011 OR, 100 XOR. C=V=0.
  - 101 SHL A by B[3:0]. C=last bit shifted out; shift of 0 gives C=0. V=0.
  - 110 SHR logical A by B[3:0]. C=last bit shifted out; shift of 0 gives C=0. V=0.
  - 111 MUL unsigned A*B, low Width bits kept. C=V=1 iff the high half of the full product is non-zero.
- Flags Z=(result==0), N=result[Width-1], for every op.
- Bus=ResOut ? result : high-Z, purely combinational from the result register.
- ResOut during MUL drives the previous (stale) result; the result register is unchanged until the load edge.
- Result and Flags hold indefinitely between operations.

Optional Feature:
Macro ALU_MULHI_EN.
- Defined: adds input ResHiOut (1 bit). A multiply also loads the high Width bits of the product into a hi register, which is reset to 0 and is otherwise untouched by non-MUL ops. ResHiOut=1 drives the hi register on Bus. If ResOut and ResHiOut are both 1, ResOut wins.
- Not defined: ResHiOut port and hi register absent; the high half of the product is discarded except for its effect on C/V.

Test Plan:
- Reset: hold Rst_n=0 with ResOut=1 -> Bus=0x0000, Flags=0, Busy=0, Done=0. Assert Rst_n=0 mid-MUL -> immediate IDLE, no Done pulse.
- ADD: OpA=0x7FFF, OpB=0x0001, Op=000, 1-cycle Start -> next cycle Done=1, result 0x8000, Flags Z0 N1 C0 V1. Then ResOut=1 -> Bus=0x8000. ResOut=0 -> Bus=Z.
- SUB and logic ops:
  - 0x0003-0x0005 -> 0xFFFE, C=1, N=1.
  - 0x00F0 AND 0x0F0F -> 0x0000, Z=1.
  - 0xAAAA XOR 0xAAAA -> 0, Z=1.
- Shifts:
  - SHL 0x8001 by 1 -> 0x0002, C=1.
  - SHR 0x0003 by 2 -> 0x0000, Z=1, C=1.
  - SHL by 0 -> A unchanged, C=0.
- MUL timing:
  - 0x0123*0x0010 -> Busy high for exactly 16 cycles; Done after 17 edges counted from the Start sample edge; result 0x1230, C=V=0.
  - 0x1000*0x0100 -> result 0x0000, Z=1, C=V=1. With ALU_MULHI_EN, ResHiOut=1 -> Bus=0x0010.
- Handshake edges:
  - Start pulsed during MUL -> ignored, multiply result unaffected.
  - Start held high across the Done cycle -> second op accepted from DONE with no IDLE gap.
  - ResOut asserted during MUL -> Bus shows the prior result.
